// File: rtl/fetch_unit.sv
// PC/fetch stage: IDLE/RUN/DONE sequencer, sequential or BNE-redirected PC, saturating cycle count.
// Latency: instr/opcode combinational from pc; done/fault registered; hold freezes pc/state for the cycle.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int IW    = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  prog_end,
  input  logic             hold,
  input  logic             branch,
  input  logic             taken,
  input  logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [IW-1:0]    imem_data,
  output logic [IW-1:0]    instr,
  output logic [2:0]       opcode,
  output logic             valid,
  output logic [PC_W-1:0]  pc,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [PC_W-1:0]  PC_MAX  = {PC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic             done_nxt, fault_nxt;
  logic [CNT_W-1:0] cycles_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= '0;
      done   <= 1'b0;
      fault  <= 1'b0;
      cycles <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      done   <= done_nxt;
      fault  <= fault_nxt;
      cycles <= cycles_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    done_nxt   = done;
    fault_nxt  = fault;
    cycles_nxt = cycles;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt  = RUN;
          pc_nxt     = '0;
          done_nxt   = 1'b0;
          fault_nxt  = 1'b0;
          cycles_nxt = '0;
        end
      end
      RUN: begin
        // Held cycles still count: they are part of the program's run time.
        if (cycles != CNT_MAX)
          cycles_nxt = cycles + CNT_W'(1);
        if (!hold) begin
          if (branch && taken) begin
            pc_nxt = target;
          end else if (pc == prog_end) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else if (pc == PC_MAX) begin
            // Running off the top of memory traps instead of wrapping to 0.
            state_nxt = DONE;
            done_nxt  = 1'b1;
            fault_nxt = 1'b1;
          end else begin
            pc_nxt = pc + PC_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_addr = pc;
    valid     = (state == RUN) && !hold;
    instr     = (state == RUN) ? imem_data : '0;
    opcode    = instr[IW-1:IW-3];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default-width instance plus a PC_W=4/CNT_W=3 instance for overflow and saturation.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset, start, hold, branch, taken;
  logic [9:0] prog_end, target, imem_addr, pc;
  logic [8:0] imem_data, instr;
  logic [2:0] opcode;
  logic       valid, done, fault;
  logic [15:0] cycles;

  logic       start4, branch4, taken4;
  logic [3:0] prog_end4, target4, imem_addr4, pc4;
  logic [8:0] imem_data4, instr4;
  logic [2:0] opcode4;
  logic       valid4, done4, fault4;
  logic [2:0] cycles4;

  int cmp = 0;
  int err = 0;

  always #5 clk = ~clk;

  // Instruction memory model: opcode field is the low address bits xor 3'b101.
  assign imem_data  = {imem_addr[2:0] ^ 3'b101, imem_addr[5:0]};
  assign imem_data4 = {imem_addr4[2:0] ^ 3'b101, 2'b00, imem_addr4};

  fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .prog_end(prog_end), .hold(hold),
    .branch(branch), .taken(taken), .target(target), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr(instr), .opcode(opcode), .valid(valid),
    .pc(pc), .done(done), .fault(fault), .cycles(cycles)
  );

  fetch_unit #(.PC_W(4), .IW(9), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .prog_end(prog_end4), .hold(1'b0),
    .branch(branch4), .taken(taken4), .target(target4), .imem_addr(imem_addr4),
    .imem_data(imem_data4), .instr(instr4), .opcode(opcode4), .valid(valid4),
    .pc(pc4), .done(done4), .fault(fault4), .cycles(cycles4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp_op;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    cmp++; if ({pc, done, fault, valid, cycles, instr} !== '0) begin err++;
      $display("FAIL reset_init: pc=%0d done=%0d fault=%0d valid=%0d cycles=%0d instr=%0h want all 0",
               pc, done, fault, valid, cycles, instr); end
    cmp++; if ({pc4, done4, fault4, cycles4} !== '0) begin err++;
      $display("FAIL reset_init4: pc=%0d done=%0d fault=%0d cycles=%0d want 0", pc4, done4, fault4, cycles4); end
    prog_end = 10'd100;
    start = 1'b1; step(); start = 1'b0;
    exp_op = 3'd0 ^ 3'b101;
    cmp++; if ({valid, opcode} !== {1'b1, exp_op}) begin err++;
      $display("FAIL first_fetch: valid=%0d opcode=%0d want 1 %0d", valid, opcode, exp_op); end
    repeat (5) step();
    cmp++; if (pc !== 10'd5) begin err++; $display("FAIL mid_run_pc: got %0d want 5", pc); end
    reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    cmp++; if ({pc, done, fault, valid, cycles} !== '0) begin err++;
      $display("FAIL reset_mid_run: pc=%0d done=%0d fault=%0d valid=%0d cycles=%0d want 0",
               pc, done, fault, valid, cycles); end
  endtask

  task automatic test_sequential();
    logic [9:0] exp_pc;
    logic [2:0] exp_op;
    prog_end = 10'd3;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 10'(i);
      exp_op = exp_pc[2:0] ^ 3'b101;
      cmp++; if ({pc, valid, done, opcode} !== {exp_pc, 1'b1, 1'b0, exp_op}) begin err++;
        $display("FAIL seq_pc%0d: pc=%0d valid=%0d done=%0d op=%0d want %0d 1 0 %0d",
                 i, pc, valid, done, opcode, exp_pc, exp_op); end
      step();
    end
    cmp++; if ({done, valid, pc, cycles, instr} !== {1'b1, 1'b0, 10'd3, 16'd4, 9'd0}) begin err++;
      $display("FAIL seq_done: done=%0d valid=%0d pc=%0d cycles=%0d instr=%0h want 1 0 3 4 0",
               done, valid, pc, cycles, instr); end
    step();
    cmp++; if ({done, pc, cycles} !== {1'b1, 10'd3, 16'd4}) begin err++;
      $display("FAIL seq_done_hold: done=%0d pc=%0d cycles=%0d want 1 3 4", done, pc, cycles); end
  endtask

  task automatic test_branch();
    prog_end = 10'd8;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    branch = 1'b1; taken = 1'b1; target = 10'd7;
    step();
    branch = 1'b0; taken = 1'b0;
    cmp++; if ({pc, valid} !== {10'd7, 1'b1}) begin err++;
      $display("FAIL branch_taken: pc=%0d valid=%0d want 7 1", pc, valid); end
    step();
    cmp++; if (pc !== 10'd8) begin err++; $display("FAIL branch_next: pc=%0d want 8", pc); end
    step();
    cmp++; if ({done, pc, cycles} !== {1'b1, 10'd8, 16'd5}) begin err++;
      $display("FAIL branch_done: done=%0d pc=%0d cycles=%0d want 1 8 5", done, pc, cycles); end
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    branch = 1'b1; taken = 1'b0; target = 10'd7;
    step();
    branch = 1'b0;
    cmp++; if (pc !== 10'd3) begin err++; $display("FAIL branch_not_taken: pc=%0d want 3", pc); end
    start = 1'b1; step(); start = 1'b0;
    cmp++; if ({pc, done, valid} !== {10'd4, 1'b0, 1'b1}) begin err++;
      $display("FAIL start_in_run: pc=%0d done=%0d valid=%0d want 4 0 1", pc, done, valid); end
    repeat (5) step();
    cmp++; if ({done, pc, cycles} !== {1'b1, 10'd8, 16'd9}) begin err++;
      $display("FAIL not_taken_done: done=%0d pc=%0d cycles=%0d want 1 8 9", done, pc, cycles); end
  endtask

  task automatic test_loop_end();
    prog_end = 10'd4;
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    cmp++; if (pc !== 10'd4) begin err++; $display("FAIL loop_at_end: pc=%0d want 4", pc); end
    branch = 1'b1; taken = 1'b1; target = 10'd1;
    step();
    branch = 1'b0; taken = 1'b0;
    cmp++; if ({pc, done, valid} !== {10'd1, 1'b0, 1'b1}) begin err++;
      $display("FAIL loop_back: pc=%0d done=%0d valid=%0d want 1 0 1", pc, done, valid); end
    repeat (3) step();
    cmp++; if ({pc, done} !== {10'd4, 1'b0}) begin err++;
      $display("FAIL loop_second_end: pc=%0d done=%0d want 4 0", pc, done); end
    step();
    cmp++; if ({done, pc, cycles} !== {1'b1, 10'd4, 16'd9}) begin err++;
      $display("FAIL loop_done: done=%0d pc=%0d cycles=%0d want 1 4 9", done, pc, cycles); end
  endtask

  task automatic test_hold();
    prog_end = 10'd3;
    start = 1'b1; step(); start = 1'b0;
    step();
    hold = 1'b1;
    #1;
    cmp++; if ({pc, valid, cycles} !== {10'd1, 1'b0, 16'd1}) begin err++;
      $display("FAIL hold_enter: pc=%0d valid=%0d cycles=%0d want 1 0 1", pc, valid, cycles); end
    repeat (3) step();
    cmp++; if ({pc, valid, cycles} !== {10'd1, 1'b0, 16'd4}) begin err++;
      $display("FAIL hold_3: pc=%0d valid=%0d cycles=%0d want 1 0 4", pc, valid, cycles); end
    hold = 1'b0;
    step();
    cmp++; if ({pc, valid, cycles} !== {10'd2, 1'b1, 16'd5}) begin err++;
      $display("FAIL hold_resume: pc=%0d valid=%0d cycles=%0d want 2 1 5", pc, valid, cycles); end
    step(); step();
    cmp++; if ({done, pc, cycles} !== {1'b1, 10'd3, 16'd7}) begin err++;
      $display("FAIL hold_done: done=%0d pc=%0d cycles=%0d want 1 3 7", done, pc, cycles); end
  endtask

  task automatic test_overflow();
    prog_end4 = 4'd0;
    start4 = 1'b1; step(); start4 = 1'b0;
    branch4 = 1'b1; taken4 = 1'b1; target4 = 4'd14;
    step();
    branch4 = 1'b0; taken4 = 1'b0;
    cmp++; if ({pc4, valid4, done4} !== {4'd14, 1'b1, 1'b0}) begin err++;
      $display("FAIL ovf_branch_over_end: pc=%0d valid=%0d done=%0d want 14 1 0", pc4, valid4, done4); end
    step();
    cmp++; if ({pc4, opcode4} !== {4'd15, 3'd2}) begin err++;
      $display("FAIL ovf_top: pc=%0d op=%0d want 15 2", pc4, opcode4); end
    step();
    cmp++; if ({done4, fault4, pc4, valid4, cycles4} !== {1'b1, 1'b1, 4'd15, 1'b0, 3'd3}) begin err++;
      $display("FAIL ovf_trap: done=%0d fault=%0d pc=%0d valid=%0d cycles=%0d want 1 1 15 0 3",
               done4, fault4, pc4, valid4, cycles4); end
    step();
    cmp++; if ({fault4, pc4} !== {1'b1, 4'd15}) begin err++;
      $display("FAIL ovf_sticky: fault=%0d pc=%0d want 1 15", fault4, pc4); end
    start4 = 1'b1; step(); start4 = 1'b0;
    cmp++; if ({done4, fault4, pc4, valid4, cycles4} !== {1'b0, 1'b0, 4'd0, 1'b1, 3'd0}) begin err++;
      $display("FAIL ovf_restart: done=%0d fault=%0d pc=%0d valid=%0d cycles=%0d want 0 0 0 1 0",
               done4, fault4, pc4, valid4, cycles4); end
    step();
    cmp++; if ({done4, fault4, pc4} !== {1'b1, 1'b0, 4'd0}) begin err++;
      $display("FAIL ovf_end_at0: done=%0d fault=%0d pc=%0d want 1 0 0", done4, fault4, pc4); end
  endtask

  task automatic test_saturate();
    prog_end4 = 4'd0;
    start4 = 1'b1; step(); start4 = 1'b0;
    branch4 = 1'b1; taken4 = 1'b1; target4 = 4'd0;
    repeat (9) step();
    cmp++; if ({cycles4, valid4, pc4} !== {3'd7, 1'b1, 4'd0}) begin err++;
      $display("FAIL sat_count: cycles=%0d valid=%0d pc=%0d want 7 1 0", cycles4, valid4, pc4); end
    branch4 = 1'b0; taken4 = 1'b0;
    step();
    cmp++; if ({done4, cycles4} !== {1'b1, 3'd7}) begin err++;
      $display("FAIL sat_done: done=%0d cycles=%0d want 1 7", done4, cycles4); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; branch = 1'b0; taken = 1'b0;
    prog_end = '0; target = '0;
    start4 = 1'b0; branch4 = 1'b0; taken4 = 1'b0; prog_end4 = '0; target4 = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_loop_end();
    test_hold();
    test_overflow();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and program-counter stage for the single-cycle 9-bit core. It sits directly upstream of the control decoder and drives the 3-bit opcode field into it. The unit holds the PC, addresses the instruction memory, and steps sequentially or redirects on a taken BNE. It runs a start/done program handshake and keeps a saturating cycle counter for performance reporting.

## Interface
- PC_W, default 10: program counter / instruction-memory address width.
- IW, default 9: instruction word width; opcode is bits [IW-1:IW-3].
- CNT_W, default 16: cycle counter width.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  program request; sampled only in IDLE or DONE.
- prog_end  in  PC_W  address of the last instruction of the program.
- hold  in  1  freeze PC and state this cycle (e.g. multi-cycle memory op).
- branch  in  1  Branch from control decoder for current instruction.
- taken  in  1  branch condition true (BNE operands unequal), from ALU.
- target  in  PC_W  branch destination, from OUT register.
- imem_addr  out  PC_W  instruction memory address, equals pc.
- imem_data  in  IW  instruction word, combinational read at imem_addr.
- instr  out  IW  current instruction; imem_data in RUN, else all zeros.
- opcode  out  3  instr[IW-1:IW-3], to control decoder.
- valid  out  1  high while in RUN and hold low; downstream gates RegWrite/MemWrite with it.
- pc  out  PC_W  current program counter.
- done  out  1  program finished; registered.
- fault  out  1  PC overflow occurred; registered, sticky until next start.
- cycles  out  CNT_W  RUN cycles of current/last program.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE, pc=0, done=0, fault=0, cycles=0.
- IDLE/DONE + start=1 -> RUN; pc=0, done=0, fault=0, cycles=0.
- start while in RUN is ignored.
- RUN, hold=1: pc and state unchanged; cycles still increments.
- RUN, hold=0, next-PC priority:
  - branch&taken -> pc=target, stay RUN; this includes the prog_end case, so loops back through prog_end are legal.
  - else pc==prog_end -> DONE, done=1, pc unchanged.
  - else pc=all-ones -> DONE, done=1, fault=1, pc unchanged (no wrap).
  - else pc=pc+1, modulo-free since all-ones is trapped.
- branch=1 with taken=0 behaves as sequential.
- cycles increments every RUN cycle and saturates at all-ones; frozen in IDLE/DONE.
- Outputs in DONE: done=1, valid=0, instr=0, pc holds last executed address.
- reset asserted mid-RUN: next edge forces the reset values; no residual done or fault.

## Timing
- Single-cycle core: instr/opcode are combinational from imem_data in the cycle pc is presented; branch/taken/target are sampled at the same edge that advances pc.
- start edge to first valid instruction: 1 cycle (pc=0 visible the cycle after start is sampled).
- Last instruction to done: done rises at the edge that retires prog_end.
- done, fault, pc, state, cycles are registers; valid, instr, opcode, imem_addr are combinational from state/pc/hold.
- reset dominates start at the same edge.

## Test plan
- Reset mid-RUN at pc=5 -> next cycle state IDLE, pc=0, done=0, fault=0, cycles=0, valid=0.
- Sequential run: prog_end=3, no branches, start pulse -> pc 0,1,2,3 on consecutive cycles with valid=1; done=1 the cycle after pc=3; cycles=4.
- Branch: at pc=2, branch=1, taken=1, target=7, prog_end=8 -> pc sequence 0,1,2,7,8, then done; with taken=0, pc goes 2->3.
- Loop at end: pc=prog_end=4 with branch&taken, target=1 -> pc=1 and stays in RUN. Next pass with taken=0 -> done.
- hold=1 for 3 cycles at pc=1 -> pc stays 1 and valid=0 during hold; cycles advances by 3; resumes to 2 after hold drops.
- Overflow: PC_W=4, prog_end=15 unreachable via target=14 and no branch at 14,15 is prog_end; retarget prog_end=0 and run to pc=15 -> done=1, fault=1, pc=15. A start in DONE clears both and restarts at pc=0.
